// File: rtl/code_entry_unit.sv
// Keypad code entry register with stored-code compare.
// Ports: clk, rst_n (async, active-low), digit_valid/digit keypad strobe,
// clear_entry/accept_digit/load_code controller requests; outputs done,
// match, entry_count, entry_digits (newest digit in [3:0]), code_set,
// timeout_pulse. Optional idle timeout: define SAFE_ENTRY_TIMEOUT_EN.
module code_entry_unit #(
    parameter int CODE_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    input  logic                  clear_entry,
    input  logic                  accept_digit,
    input  logic                  load_code,
    output logic                  done,
    output logic                  match,
    output logic [2:0]            entry_count,
    output logic [4*CODE_LEN-1:0] entry_digits,
    output logic                  code_set,
    output logic                  timeout_pulse
);

    localparam int         EW   = 4 * CODE_LEN;
    localparam logic [2:0] FULL = 3'(CODE_LEN);

    logic [EW-1:0] stored_code;
    logic          take;
    logic          expire;

    assign take = accept_digit & digit_valid & (digit <= 4'd9)
                & (entry_count < FULL) & ~clear_entry;

    assign done  = (entry_count == FULL);
    assign match = done & code_set & (entry_digits == stored_code);

`ifdef SAFE_ENTRY_TIMEOUT_EN
    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;
    logic          idle;

    // A partial entry waiting for more digits while the controller allows
    // entry; a taken digit or a clear restarts the wait.
    assign idle = accept_digit & (entry_count != 3'd0)
                & (entry_count < FULL) & ~take & ~clear_entry;

    assign expire = idle & (idle_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= expire;
            if (idle && !expire) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign timeout_pulse  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_digits <= '0;
            entry_count  <= '0;
        end else if (clear_entry || expire) begin
            entry_digits <= '0;
            entry_count  <= '0;
        end else if (take) begin
            entry_digits <= (entry_digits << 4) | EW'(digit);
            entry_count  <= entry_count + 3'd1;
        end
    end

    // Load samples the pre-clear entry, so a same-cycle clear still loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_code <= '0;
            code_set    <= 1'b0;
        end else if (load_code && done) begin
            stored_code <= entry_digits;
            code_set    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_code_entry_unit.sv
// Self-checking bench for code_entry_unit: queue-based model compared
// every cycle, plus directed literal checks.
module tb_code_entry_unit;

    localparam int CL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        clear_entry = 1'b0;
    logic        accept_digit = 1'b0;
    logic        load_code = 1'b0;
    logic        done;
    logic        match;
    logic [2:0]  entry_count;
    logic [15:0] entry_digits;
    logic        code_set;
    logic        timeout_pulse;

    int pass_cnt = 0;
    int total    = 0;

    code_entry_unit #(.CODE_LEN(CL), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .clear_entry  (clear_entry),
        .accept_digit (accept_digit),
        .load_code    (load_code),
        .done         (done),
        .match        (match),
        .entry_count  (entry_count),
        .entry_digits (entry_digits),
        .code_set     (code_set),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Model: the entry is a list of digits, the stored code another list.
    int q[$];
    int sq[$];
    bit cs;
    int idle;
    bit tp;
    bit take;

    function automatic logic [31:0] pack(input int a[$]);
        logic [31:0] v = 0;
        foreach (a[i]) v = (v << 4) | 32'(a[i]);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            sq.delete();
            cs   = 0;
            idle = 0;
            tp   = 0;
        end else begin
            take = accept_digit && digit_valid && digit <= 9 &&
                   q.size() < CL && !clear_entry;
            tp = 0;
            if (load_code && q.size() == CL) begin
                sq = q;
                cs = 1;
            end
`ifdef SAFE_ENTRY_TIMEOUT_EN
            if (accept_digit && q.size() > 0 && q.size() < CL &&
                !take && !clear_entry) begin
                idle++;
                if (idle == TO) begin
                    idle = 0;
                    tp   = 1;
                    q.delete();
                end
            end else begin
                idle = 0;
            end
`endif
            if (clear_entry) q.delete();
            else if (take) q.push_back(int'(digit));
        end
    end

    always @(negedge clk) begin
        chk("entry_digits", 32'(entry_digits), pack(q));
        chk("entry_count", 32'(entry_count), 32'(q.size()));
        chk("done", 32'(done), 32'(q.size() == CL));
        chk("match", 32'(match),
            32'(q.size() == CL && cs && pack(q) == pack(sq)));
        chk("code_set", 32'(code_set), 32'(cs));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(tp));
    end

    // One clock edge with the given inputs; returns 1 time unit after it.
    task automatic cyc(input logic v, input logic [3:0] d, input logic acc,
                       input logic clr, input logic ld);
        @(negedge clk);
        #1;
        digit_valid  = v;
        digit        = d;
        accept_digit = acc;
        clear_entry  = clr;
        load_code    = ld;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        clear_entry = 1'b0;
        load_code   = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        cyc(1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(entry_count), 32'd0);
        chk("rst_digits", 32'(entry_digits), 32'd0);
        chk("rst_code_set", 32'(code_set), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #12;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_match", 32'(match), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_digits", 32'(entry_digits), 32'h1234);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        chk("t1_code_set", 32'(code_set), 32'd1);
        chk("t1_match", 32'(match), 32'd1);

        clr();
        key(4'd1); key(4'd2); key(4'd3); key(4'd5);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_nomatch", 32'(match), 32'd0);
        clr();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("t2_match", 32'(match), 32'd1);

        clr();
        key(4'd7);
        key(4'd12);
        cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        chk("t3_count", 32'(entry_count), 32'd1);
        chk("t3_digits", 32'(entry_digits), 32'h0007);

        cyc(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("t4_clr_wins", 32'(entry_count), 32'd0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("t4_full", 32'(entry_digits), 32'h1234);

        do_reset();
        key(4'd1); key(4'd2);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        chk("t5_partial_load", 32'(code_set), 32'd0);
        clr();
        key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("t5_ld_clr_count", 32'(entry_count), 32'd0);
        chk("t5_ld_clr_set", 32'(code_set), 32'd1);
        key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        chk("t5_stored_9876", 32'(match), 32'd1);
        clr();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("t5_other_code", 32'(match), 32'd0);

        clr();
        key(4'd3);
        for (int i = 0; i < TO - 1; i++) idle_cyc();
        chk("t6_pre_count", 32'(entry_count), 32'd1);
        idle_cyc();
`ifdef SAFE_ENTRY_TIMEOUT_EN
        chk("t6_expired", 32'(entry_count), 32'd0);
        chk("t6_pulse", 32'(timeout_pulse), 32'd1);
`else
        chk("t6_kept", 32'(entry_count), 32'd1);
        chk("t6_no_pulse", 32'(timeout_pulse), 32'd0);
`endif
        idle_cyc();
        chk("t6_pulse_once", 32'(timeout_pulse), 32'd0);

        clr();
        key(4'd3);
        for (int i = 0; i < TO - 1; i++) idle_cyc();
        key(4'd4);
        chk("t7_count", 32'(entry_count), 32'd2);
        chk("t7_no_pulse", 32'(timeout_pulse), 32'd0);
        idle_cyc();
        chk("t7_no_pulse2", 32'(timeout_pulse), 32'd0);
        clr();

        // Asynchronous reset between clock edges drops a partial entry.
        key(4'd1); key(4'd2); key(4'd3);
        do_reset();
        idle_cyc();
        idle_cyc();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
